// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the CPU data port (master) and the memory responder (slave).
interface data_mem_responder_if;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic        iWriteEnable;
  logic        iReadEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] oReadData;
  logic        oReady;
  logic        oError;
  logic        oBusy;

  modport master (
    output iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable,
    input  oReadData, oReady, oError, oBusy
  );

  modport slave (
    input  iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable,
    output oReadData, oReady, oError, oBusy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised RAM responder for the CPU data bus: captures one request,
// inserts WAIT_CYCLES wait states, executes it, then pulses oReady (with oError).
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   ram [DEPTH];

  logic [31:0]   off;
  logic          req;
  logic          bad;
  logic          unused_off;

  assign off        = bus.iAddress - BASE_ADDR;
  assign unused_off = ^{off[31:AW+2], off[1:0]};
  assign req        = bus.iReadEnable | bus.iWriteEnable;

  // 33-bit compare so a window ending at the top of the address space cannot wrap
  assign bad = ({1'b0, bus.iAddress} < {1'b0, BASE_ADDR}) ||
               ({1'b0, bus.iAddress} >= LIMIT) ||
               (bus.iByteEnable == 4'b0000) ||
               (bus.iReadEnable && bus.iWriteEnable);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = off[AW+1:2];
          wdata_d = bus.iWriteData;
          be_d    = bus.iByteEnable;
          we_d    = bus.iWriteEnable;
          err_d   = bad;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = S_ACCESS;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACCESS;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (!err_q && !we_q) rdata_d = ram[idx_q];
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM is not reset; an asynchronous reset before ACCESS leaves state_q out of ACCESS
  always_ff @(posedge iCLK) begin
    if (state_q == S_ACCESS && we_q && !err_q) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be_q[k]) ram[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign bus.oReadData = rdata_q;
  assign bus.oReady    = (state_q == S_RESP);
  assign bus.oError    = (state_q == S_RESP) && err_q;
  assign bus.oBusy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder with WAIT_CYCLES=1 and WAIT_CYCLES=0 instances.
module tb_data_mem_responder;
  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          DEPTH = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel;
  logic [31:0] addr, wdata;
  logic        we, re;
  logic [3:0]  be;

  data_mem_responder_if bus1 ();
  data_mem_responder_if bus0 ();

  assign bus1.iAddress     = addr;
  assign bus1.iWriteData   = wdata;
  assign bus1.iByteEnable  = be;
  assign bus1.iWriteEnable = sel & we;
  assign bus1.iReadEnable  = sel & re;
  assign bus0.iAddress     = addr;
  assign bus0.iWriteData   = wdata;
  assign bus0.iByteEnable  = be;
  assign bus0.iWriteEnable = !sel & we;
  assign bus0.iReadEnable  = !sel & re;

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(1)) dut1 (
    .iCLK(clk), .iRST(rst_n), .bus(bus1.slave));
  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .iCLK(clk), .iRST(rst_n), .bus(bus0.slave));

  logic        rdy, rerr, rbusy;
  logic [31:0] rdat;
  assign rdy   = sel ? bus1.oReady    : bus0.oReady;
  assign rerr  = sel ? bus1.oError    : bus0.oError;
  assign rbusy = sel ? bus1.oBusy     : bus0.oBusy;
  assign rdat  = sel ? bus1.oReadData : bus0.oReadData;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] m1[int];
  logic [31:0] m0[int];
  logic [31:0] last1 = '0;
  logic [31:0] last0 = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic req_err(input logic [31:0] a, input logic [3:0] b,
                                   input logic w, input logic r);
    return ({1'b0, a} < {1'b0, BASE}) ||
           ({1'b0, a} >= ({1'b0, BASE} + 33'(4 * DEPTH))) ||
           (b == 4'b0000) || (w && r);
  endfunction

  task automatic model(input logic s, input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    int          idx;
    logic [31:0] word;
    logic        e;
    e   = req_err(a, b, w, r);
    idx = int'((a - BASE) >> 2);
    if (!e) begin
      if (s) word = m1.exists(idx) ? m1[idx] : '0;
      else   word = m0.exists(idx) ? m0[idx] : '0;
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) word[8*k +: 8] = d[8*k +: 8];
        if (s) m1[idx] = word;
        else   m0[idx] = word;
      end else if (s) last1 = word;
      else            last0 = word;
    end
    sb.push_back('{rdata: (s ? last1 : last0), err: e});
  endtask

  task automatic wait_resp(input string tag, input int lat_exp);
    int    n;
    resp_t exp;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy && n < 20);
    check({tag, "_lat"}, n, lat_exp);
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = '0;
    if (rdy) begin
      check({tag, "_err"},   rerr,  exp.err);
      check({tag, "_rdata"}, rdat,  exp.rdata);
      check({tag, "_busy"},  rbusy, 1);
    end
  endtask

  task automatic do_access(input logic s, input logic w, input logic r, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b, input string tag);
    @(negedge clk);
    sel = s; we = w; re = r; addr = a; wdata = d; be = b;
    model(s, w, r, a, d, b);
    @(posedge clk);
    #1;
    addr  = $urandom;
    wdata = ~d;
    be    = 4'($urandom);
    wait_resp(tag, s ? 3 : 2);
    we = 1'b0;
    re = 1'b0;
    @(negedge clk);
    check({tag, "_rdy_low"}, rdy,  0);
    check({tag, "_err_low"}, rerr, 0);
  endtask

  initial begin
    resp_t exp;
    int    nr, gap, cyc;
    sel = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (2) @(negedge clk);
    check("rst_rdy1",   bus1.oReady,    0);
    check("rst_err1",   bus1.oError,    0);
    check("rst_busy1",  bus1.oBusy,     0);
    check("rst_rdata1", bus1.oReadData, 0);
    check("rst_busy0",  bus0.oBusy,     0);
    rst_n = 1'b1;

    do_access(1, 1, 0, 32'h10010008, 32'hDEADBEEF, 4'hF, "wr8");
    do_access(1, 0, 1, 32'h10010008, 32'h0, 4'hF, "rd8");
    check("rd8_const", rdat, 32'hDEADBEEF);

    do_access(1, 1, 0, 32'h10010010, 32'h11223344, 4'hF, "wr10");
    do_access(1, 1, 0, 32'h10010010, 32'h0000AA00, 4'b0010, "wr10_lane");
    do_access(1, 0, 1, 32'h10010010, 32'h0, 4'hF, "rd10");
    check("rd10_const", rdat, 32'h1122AA44);

    do_access(1, 0, 1, 32'h10011000, 32'h0, 4'hF, "rd_oor");
    do_access(1, 1, 0, 32'h10010FFC, 32'h0F0F0F0F, 4'hF, "wr_last");
    do_access(1, 1, 0, 32'h1000FFFC, 32'h99999999, 4'hF, "wr_low");
    do_access(1, 0, 1, 32'h10010FFC, 32'h0, 4'hF, "rd_last");
    do_access(1, 1, 1, 32'h10010008, 32'h0, 4'hF, "rw_both");
    do_access(1, 1, 0, 32'h10010008, 32'h0, 4'h0, "be_zero");
    do_access(1, 0, 1, 32'h1001000B, 32'h0, 4'hF, "rd8_unal");
    check("rd8_keep", rdat, 32'hDEADBEEF);

    // WAIT_CYCLES=0 with enables held through RESP: two accesses, one idle cycle between
    @(negedge clk);
    sel = 1'b0; we = 1'b1; re = 1'b0; addr = 32'h10010040; wdata = 32'h0BADC0DE; be = 4'hF;
    model(0, 1, 0, addr, wdata, be);
    model(0, 1, 0, addr, wdata, be);
    nr = 0; gap = 0; cyc = 0;
    while (nr < 2 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus0.oReady) begin
        nr++;
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        check("b2b_err", bus0.oError, exp.err);
        if (nr == 2) we = 1'b0;
      end else if (nr == 1 && !bus0.oBusy) gap++;
    end
    we = 1'b0;
    sb.delete();
    check("b2b_count", nr, 2);
    check("b2b_gap", gap, 1);
    do_access(0, 0, 1, 32'h10010040, 32'h0, 4'hF, "b2b_rd");
    check("b2b_rd_const", rdat, 32'h0BADC0DE);

    // reset during WAIT aborts the write
    do_access(1, 1, 0, 32'h10010020, 32'hCAFEF00D, 4'hF, "wr20");
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = 32'h10010020; wdata = 32'h12345678; be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("rstw_busy", bus1.oBusy, 1);
    rst_n = 1'b0;
    #1;
    check("rstw_rdy",   bus1.oReady,    0);
    check("rstw_err",   bus1.oError,    0);
    check("rstw_busy0", bus1.oBusy,     0);
    check("rstw_rdata", bus1.oReadData, 0);
    we = 1'b0; last1 = '0; last0 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_access(1, 0, 1, 32'h10010020, 32'h0, 4'hF, "rstw_rd");
    check("rstw_old", rdat, 32'hCAFEF00D);

    // reset during RESP keeps the committed write
    @(negedge clk);
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = 32'h10010024; wdata = 32'h5A5A5A5A; be = 4'hF;
    model(1, 1, 0, addr, wdata, be);
    @(posedge clk);
    wait_resp("rstr", 3);
    rst_n = 1'b0;
    #1;
    check("rstr_rdy",  bus1.oReady, 0);
    check("rstr_busy", bus1.oBusy,  0);
    we = 1'b0; last1 = '0; last0 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_access(1, 0, 1, 32'h10010024, 32'h0, 4'hF, "rstr_rd");
    check("rstr_new", rdat, 32'h5A5A5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
